// File: rtl/blu_pkg.sv
// rtl/blu_pkg.sv - shared types for the branch logic unit and branch resolution
package blu_pkg;

    // Condition evaluated by the BLU; the result lands in out[0].
    typedef enum logic [2:0] {
        BLU_OP_EQUAL,
        BLU_OP_NOT_EQUAL,
        BLU_OP_LESS_THAN_SIGNED,
        BLU_OP_GREATER_EQUAL_SIGNED,
        BLU_OP_LESS_THAN_UNSIGNED,
        BLU_OP_GREATER_EQUAL_UNSIGNED
    } BLU_opcode;

    // Control-transfer class of the instruction in execute.
    typedef enum logic [1:0] {
        BR_NONE,
        BR_COND,
        BR_JAL,
        BR_JALR
    } BR_kind;

    // IDLE: nothing held; BUSY: writeback and redirect (if any) pending;
    // WAIT_OUT: only writeback pending; WAIT_REDIR: only redirect pending.
    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        WAIT_OUT,
        WAIT_REDIR
    } BR_state;

    localparam int BR_PC_STEP = 4;

endpackage

// File: rtl/branch_resolve_if.sv
// rtl/branch_resolve_if.sv - instruction, writeback and redirect signals of branch_resolve
// Ports (slave = branch_resolve side):
//   issue     : in_valid/in_ready, kind, blu_op, pc, imm, rs1, rs2, pred_pc
//   writeback : out_valid/out_ready, out_link, out_exc
//   redirect  : redirect_valid/redirect_ack, redirect_pc, flush
//   control   : squash (trap kill), mispredict_count (status)
interface branch_resolve_if #(
    parameter int XLEN = 32
);
    import blu_pkg::*;

    logic            in_valid;
    logic            in_ready;
    BR_kind          kind;
    BLU_opcode       blu_op;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] imm;
    logic [XLEN-1:0] rs1;
    logic [XLEN-1:0] rs2;
    logic [XLEN-1:0] pred_pc;

    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] out_link;
    logic            out_exc;

    logic            redirect_valid;
    logic            redirect_ack;
    logic [XLEN-1:0] redirect_pc;
    logic            flush;

    logic            squash;
    logic [31:0]     mispredict_count;

    modport master (
        output in_valid, kind, blu_op, pc, imm, rs1, rs2, pred_pc,
        output out_ready, redirect_ack, squash,
        input  in_ready, out_valid, out_link, out_exc,
        input  redirect_valid, redirect_pc, flush, mispredict_count
    );

    modport slave (
        input  in_valid, kind, blu_op, pc, imm, rs1, rs2, pred_pc,
        input  out_ready, redirect_ack, squash,
        output in_ready, out_valid, out_link, out_exc,
        output redirect_valid, redirect_pc, flush, mispredict_count
    );

endinterface

// File: rtl/branch_resolve_blu.sv
// rtl/branch_resolve_blu.sv - branch logic unit: combinational condition evaluation
// Ports:
//   in1, in2 : operands (rs1, rs2)
//   op       : condition select
//   out      : condition result in bit 0, upper bits zero
module BLU
    import blu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] in1,
    input  logic [XLEN-1:0] in2,
    input  BLU_opcode       op,
    output logic [XLEN-1:0] out
);

    always_comb begin
        out = '0;
        case (op)
            BLU_OP_EQUAL:                  out[0] = (in1 == in2);
            BLU_OP_NOT_EQUAL:              out[0] = (in1 != in2);
            BLU_OP_LESS_THAN_SIGNED:       out[0] = ($signed(in1) <  $signed(in2));
            BLU_OP_GREATER_EQUAL_SIGNED:   out[0] = ($signed(in1) >= $signed(in2));
            BLU_OP_LESS_THAN_UNSIGNED:     out[0] = (in1 <  in2);
            BLU_OP_GREATER_EQUAL_UNSIGNED: out[0] = (in1 >= in2);
            default:                       out[0] = 1'b0;
        endcase
    end

endmodule

// File: rtl/branch_resolve.sv
// rtl/branch_resolve.sv - execute-stage branch resolution with fetch redirect
// Ports:
//   clk, reset_n : clock, asynchronous active-low reset
//   bus          : branch_resolve_if.slave (issue, writeback, redirect, squash, count)
module branch_resolve
    import blu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic              clk,
    input  logic              reset_n,
    branch_resolve_if.slave   bus
);

    BR_state         state, state_next;
    logic [XLEN-1:0] link_q;
    logic            exc_q;
    logic [XLEN-1:0] redir_pc_q;
    logic            redir_req_q;
    logic            flush_q;
    logic [31:0]     count_q;

    logic [XLEN-1:0] blu_out;
    logic            unused_blu;

    BLU #(.XLEN(XLEN)) u_blu (
        .in1 (bus.rs1),
        .in2 (bus.rs2),
        .op  (bus.blu_op),
        .out (blu_out)
    );

    assign unused_blu = ^blu_out[XLEN-1:1];

    // Resolution of the instruction currently offered on the issue side.
    logic [XLEN-1:0] seq_pc, jalr_sum, target, next_pc, link;
    logic            taken, exc, mispredict;

    always_comb begin
        seq_pc   = bus.pc + XLEN'(BR_PC_STEP);
        jalr_sum = bus.rs1 + bus.imm;
        target   = bus.pc + bus.imm;
        taken    = 1'b0;
        link     = '0;
        case (bus.kind)
            BR_COND: taken = blu_out[0];
            BR_JAL: begin
                taken = 1'b1;
                link  = seq_pc;
            end
            BR_JALR: begin
                taken  = 1'b1;
                target = {jalr_sum[XLEN-1:1], 1'b0};
                link   = seq_pc;
            end
            default: taken = 1'b0;
        endcase
        next_pc    = taken ? target : seq_pc;
        exc        = taken && (target[1:0] != 2'b00);
        mispredict = !exc && (next_pc != bus.pred_pc);
    end

    // Pending items are implied by the state; a BUSY entry without a
    // mispredict carries no redirect, so redir_req_q gates the valid.
    logic out_fire, redir_fire, out_done, redir_done, accept;

    assign bus.out_valid      = (state == BUSY) || (state == WAIT_OUT);
    assign bus.redirect_valid = ((state == BUSY) || (state == WAIT_REDIR)) && redir_req_q;
    assign out_fire   = bus.out_valid && bus.out_ready;
    assign redir_fire = bus.redirect_valid && bus.redirect_ack;
    assign out_done   = !bus.out_valid || out_fire;
    assign redir_done = !bus.redirect_valid || redir_fire;

    // Ready whenever everything still held completes this cycle.
    assign bus.in_ready = out_done && redir_done;
    // A trap squash kills both the held instruction and any same-cycle issue.
    assign accept       = bus.in_valid && bus.in_ready && !bus.squash;

    always_comb begin
        state_next = state;
        if (bus.squash) begin
            state_next = IDLE;
        end else if (accept) begin
            state_next = BUSY;
        end else begin
            case (state)
                BUSY: begin
                    if (out_done && redir_done) state_next = IDLE;
                    else if (out_done)          state_next = WAIT_REDIR;
                    else if (redir_done)        state_next = WAIT_OUT;
                end
                WAIT_OUT:   if (out_done)   state_next = IDLE;
                WAIT_REDIR: if (redir_done) state_next = IDLE;
                default:    state_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Redirect only ever rises on the cycle after an accept, so the flush
    // pulse and the count update both key off the accepting edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            link_q      <= '0;
            exc_q       <= 1'b0;
            redir_pc_q  <= '0;
            redir_req_q <= 1'b0;
            flush_q     <= 1'b0;
            count_q     <= '0;
        end else begin
            flush_q <= accept && mispredict;
            if (accept) begin
                link_q      <= link;
                exc_q       <= exc;
                redir_pc_q  <= next_pc;
                redir_req_q <= mispredict;
                if (mispredict && (count_q != 32'hFFFF_FFFF)) begin
                    count_q <= count_q + 32'd1;
                end
            end
        end
    end

    assign bus.out_link         = link_q;
    assign bus.out_exc          = exc_q;
    assign bus.redirect_pc      = redir_pc_q;
    assign bus.flush            = flush_q;
    assign bus.mispredict_count = count_q;

endmodule

// File: tb/tb_branch_resolve.sv
// tb/tb_branch_resolve.sv - directed self-checking bench for branch_resolve
module tb_branch_resolve;
    import blu_pkg::*;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   n_cmp = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    branch_resolve_if #(.XLEN(32)) bus ();

    branch_resolve #(.XLEN(32)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input BR_kind k, input BLU_opcode op, input logic [31:0] p,
                         input logic [31:0] im, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] pred);
        bus.kind     = k;
        bus.blu_op   = op;
        bus.pc       = p;
        bus.imm      = im;
        bus.rs1      = a;
        bus.rs2      = b;
        bus.pred_pc  = pred;
        bus.in_valid = 1'b1;
    endtask

    task automatic test_reset();
        n_cmp++; if (bus.in_ready !== 1'b1) begin n_bad++; $display("FAIL reset_in_ready got %b want 1", bus.in_ready); end
        n_cmp++; if (bus.out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid got %b want 0", bus.out_valid); end
        n_cmp++; if (bus.out_link !== 32'h0) begin n_bad++; $display("FAIL reset_out_link got %h want 0", bus.out_link); end
        n_cmp++; if (bus.out_exc !== 1'b0) begin n_bad++; $display("FAIL reset_out_exc got %b want 0", bus.out_exc); end
        n_cmp++; if (bus.redirect_valid !== 1'b0) begin n_bad++; $display("FAIL reset_redirect_valid got %b want 0", bus.redirect_valid); end
        n_cmp++; if (bus.redirect_pc !== 32'h0) begin n_bad++; $display("FAIL reset_redirect_pc got %h want 0", bus.redirect_pc); end
        n_cmp++; if (bus.flush !== 1'b0) begin n_bad++; $display("FAIL reset_flush got %b want 0", bus.flush); end
        n_cmp++; if (bus.mispredict_count !== 32'h0) begin n_bad++; $display("FAIL reset_count got %h want 0", bus.mispredict_count); end
    endtask

    task automatic test_cond_mispredict();
        bus.out_ready = 1'b1; bus.redirect_ack = 1'b1;
        drive(BR_COND, BLU_OP_EQUAL, 32'h100, 32'h20, 32'hAAAA_AAAA, 32'hAAAA_AAAA, 32'h104);
        step();
        bus.in_valid = 1'b0;
        n_cmp++; if (bus.out_valid !== 1'b1) begin n_bad++; $display("FAIL mis_out_valid got %b want 1", bus.out_valid); end
        n_cmp++; if (bus.redirect_valid !== 1'b1) begin n_bad++; $display("FAIL mis_redirect_valid got %b want 1", bus.redirect_valid); end
        n_cmp++; if (bus.redirect_pc !== 32'h120) begin n_bad++; $display("FAIL mis_redirect_pc got %h want 120", bus.redirect_pc); end
        n_cmp++; if (bus.flush !== 1'b1) begin n_bad++; $display("FAIL mis_flush got %b want 1", bus.flush); end
        n_cmp++; if (bus.mispredict_count !== 32'd1) begin n_bad++; $display("FAIL mis_count got %h want 1", bus.mispredict_count); end
        n_cmp++; if (bus.out_link !== 32'h0) begin n_bad++; $display("FAIL mis_out_link got %h want 0", bus.out_link); end
        n_cmp++; if (bus.out_exc !== 1'b0) begin n_bad++; $display("FAIL mis_out_exc got %b want 0", bus.out_exc); end
        step();
        n_cmp++; if (bus.flush !== 1'b0) begin n_bad++; $display("FAIL mis_flush_drop got %b want 0", bus.flush); end
        n_cmp++; if (bus.redirect_valid !== 1'b0) begin n_bad++; $display("FAIL mis_redirect_drop got %b want 0", bus.redirect_valid); end
        n_cmp++; if (bus.out_valid !== 1'b0) begin n_bad++; $display("FAIL mis_out_drop got %b want 0", bus.out_valid); end
    endtask

    task automatic test_cond_not_taken();
        drive(BR_COND, BLU_OP_LESS_THAN_SIGNED, 32'h200, 32'h80, 32'h7FFF_FFFF, 32'h8000_0000, 32'h204);
        step();
        bus.in_valid = 1'b0;
        n_cmp++; if (bus.out_valid !== 1'b1) begin n_bad++; $display("FAIL nt_out_valid got %b want 1", bus.out_valid); end
        n_cmp++; if (bus.redirect_valid !== 1'b0) begin n_bad++; $display("FAIL nt_redirect_valid got %b want 0", bus.redirect_valid); end
        n_cmp++; if (bus.flush !== 1'b0) begin n_bad++; $display("FAIL nt_flush got %b want 0", bus.flush); end
        n_cmp++; if (bus.mispredict_count !== 32'd1) begin n_bad++; $display("FAIL nt_count got %h want 1", bus.mispredict_count); end
        n_cmp++; if (bus.out_exc !== 1'b0) begin n_bad++; $display("FAIL nt_out_exc got %b want 0", bus.out_exc); end
        step();
    endtask

    task automatic test_jalr_exc();
        drive(BR_JALR, BLU_OP_EQUAL, 32'h40, 32'h0, 32'h203, 32'h0, 32'h44);
        step();
        bus.in_valid = 1'b0;
        n_cmp++; if (bus.out_exc !== 1'b1) begin n_bad++; $display("FAIL jalr_out_exc got %b want 1", bus.out_exc); end
        n_cmp++; if (bus.out_link !== 32'h44) begin n_bad++; $display("FAIL jalr_out_link got %h want 44", bus.out_link); end
        n_cmp++; if (bus.redirect_valid !== 1'b0) begin n_bad++; $display("FAIL jalr_redirect_valid got %b want 0", bus.redirect_valid); end
        n_cmp++; if (bus.flush !== 1'b0) begin n_bad++; $display("FAIL jalr_flush got %b want 0", bus.flush); end
        n_cmp++; if (bus.mispredict_count !== 32'd1) begin n_bad++; $display("FAIL jalr_count got %h want 1", bus.mispredict_count); end
        step();
    endtask

    task automatic test_hold();
        bus.out_ready = 1'b0; bus.redirect_ack = 1'b0;
        drive(BR_JAL, BLU_OP_EQUAL, 32'h300, 32'h100, 32'h0, 32'h0, 32'h304);
        step();
        bus.in_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            n_cmp++; if (bus.in_ready !== 1'b0) begin n_bad++; $display("FAIL hold_in_ready[%0d] got %b want 0", i, bus.in_ready); end
            n_cmp++; if (bus.out_valid !== 1'b1) begin n_bad++; $display("FAIL hold_out_valid[%0d] got %b want 1", i, bus.out_valid); end
            n_cmp++; if (bus.redirect_valid !== 1'b1) begin n_bad++; $display("FAIL hold_redirect_valid[%0d] got %b want 1", i, bus.redirect_valid); end
            n_cmp++; if (bus.redirect_pc !== 32'h400) begin n_bad++; $display("FAIL hold_redirect_pc[%0d] got %h want 400", i, bus.redirect_pc); end
            n_cmp++; if (bus.out_link !== 32'h304) begin n_bad++; $display("FAIL hold_out_link[%0d] got %h want 304", i, bus.out_link); end
            n_cmp++; if (bus.flush !== (i == 0)) begin n_bad++; $display("FAIL hold_flush[%0d] got %b want %b", i, bus.flush, (i == 0)); end
            n_cmp++; if (bus.mispredict_count !== 32'd2) begin n_bad++; $display("FAIL hold_count[%0d] got %h want 2", i, bus.mispredict_count); end
            if (i < 2) step();
        end
        bus.out_ready = 1'b1; bus.redirect_ack = 1'b1;
        drive(BR_NONE, BLU_OP_EQUAL, 32'h500, 32'h0, 32'h0, 32'h0, 32'h504);
        #1;
        n_cmp++; if (bus.in_ready !== 1'b1) begin n_bad++; $display("FAIL b2b_in_ready got %b want 1", bus.in_ready); end
        step();
        bus.in_valid = 1'b0;
        n_cmp++; if (bus.out_valid !== 1'b1) begin n_bad++; $display("FAIL b2b_out_valid got %b want 1", bus.out_valid); end
        n_cmp++; if (bus.redirect_valid !== 1'b0) begin n_bad++; $display("FAIL b2b_redirect_valid got %b want 0", bus.redirect_valid); end
        n_cmp++; if (bus.out_link !== 32'h0) begin n_bad++; $display("FAIL b2b_out_link got %h want 0", bus.out_link); end
        n_cmp++; if (bus.flush !== 1'b0) begin n_bad++; $display("FAIL b2b_flush got %b want 0", bus.flush); end
        n_cmp++; if (bus.mispredict_count !== 32'd2) begin n_bad++; $display("FAIL b2b_count got %h want 2", bus.mispredict_count); end
        step();
    endtask

    task automatic test_squash();
        bus.out_ready = 1'b1; bus.redirect_ack = 1'b0;
        drive(BR_COND, BLU_OP_EQUAL, 32'h600, 32'h40, 32'h5, 32'h5, 32'h604);
        step();
        bus.in_valid = 1'b0;
        n_cmp++; if (bus.mispredict_count !== 32'd3) begin n_bad++; $display("FAIL sq_count_pre got %h want 3", bus.mispredict_count); end
        step();
        n_cmp++; if (bus.out_valid !== 1'b0) begin n_bad++; $display("FAIL sq_wr_out_valid got %b want 0", bus.out_valid); end
        n_cmp++; if (bus.redirect_valid !== 1'b1) begin n_bad++; $display("FAIL sq_wr_redirect_valid got %b want 1", bus.redirect_valid); end
        n_cmp++; if (bus.in_ready !== 1'b0) begin n_bad++; $display("FAIL sq_wr_in_ready got %b want 0", bus.in_ready); end
        bus.squash = 1'b1;
        step();
        bus.squash = 1'b0;
        n_cmp++; if (bus.redirect_valid !== 1'b0) begin n_bad++; $display("FAIL sq_redirect_valid got %b want 0", bus.redirect_valid); end
        n_cmp++; if (bus.in_ready !== 1'b1) begin n_bad++; $display("FAIL sq_in_ready got %b want 1", bus.in_ready); end
        n_cmp++; if (bus.mispredict_count !== 32'd3) begin n_bad++; $display("FAIL sq_count got %h want 3", bus.mispredict_count); end
        bus.redirect_ack = 1'b1;
        drive(BR_JAL, BLU_OP_EQUAL, 32'h700, 32'h8, 32'h0, 32'h0, 32'h704);
        step();
        bus.in_valid = 1'b0;
        n_cmp++; if (bus.mispredict_count !== 32'd4) begin n_bad++; $display("FAIL sq_next_count got %h want 4", bus.mispredict_count); end
        n_cmp++; if (bus.redirect_pc !== 32'h708) begin n_bad++; $display("FAIL sq_next_redirect_pc got %h want 708", bus.redirect_pc); end
        n_cmp++; if (bus.flush !== 1'b1) begin n_bad++; $display("FAIL sq_next_flush got %b want 1", bus.flush); end
        step();
        bus.squash = 1'b1;
        drive(BR_JAL, BLU_OP_EQUAL, 32'h780, 32'h8, 32'h0, 32'h0, 32'h784);
        step();
        bus.squash = 1'b0; bus.in_valid = 1'b0;
        n_cmp++; if (bus.out_valid !== 1'b0) begin n_bad++; $display("FAIL sq_acc_out_valid got %b want 0", bus.out_valid); end
        n_cmp++; if (bus.redirect_valid !== 1'b0) begin n_bad++; $display("FAIL sq_acc_redirect_valid got %b want 0", bus.redirect_valid); end
        n_cmp++; if (bus.mispredict_count !== 32'd4) begin n_bad++; $display("FAIL sq_acc_count got %h want 4", bus.mispredict_count); end
    endtask

    task automatic test_saturate();
        force dut.count_q = 32'hFFFF_FFFE;
        #1;
        release dut.count_q;
        bus.out_ready = 1'b1; bus.redirect_ack = 1'b1;
        drive(BR_JAL, BLU_OP_EQUAL, 32'h800, 32'h10, 32'h0, 32'h0, 32'h804);
        step();
        n_cmp++; if (bus.mispredict_count !== 32'hFFFF_FFFF) begin n_bad++; $display("FAIL sat_inc got %h want ffffffff", bus.mispredict_count); end
        step();
        bus.in_valid = 1'b0;
        n_cmp++; if (bus.flush !== 1'b1) begin n_bad++; $display("FAIL sat_flush got %b want 1", bus.flush); end
        n_cmp++; if (bus.mispredict_count !== 32'hFFFF_FFFF) begin n_bad++; $display("FAIL sat_hold got %h want ffffffff", bus.mispredict_count); end
        step();
    endtask

    task automatic test_async_reset();
        bus.out_ready = 1'b0; bus.redirect_ack = 1'b0;
        drive(BR_JAL, BLU_OP_EQUAL, 32'h900, 32'h20, 32'h0, 32'h0, 32'h904);
        step();
        bus.in_valid = 1'b0;
        n_cmp++; if (bus.redirect_valid !== 1'b1) begin n_bad++; $display("FAIL ar_busy got %b want 1", bus.redirect_valid); end
        #2;
        reset_n = 1'b0;
        #1;
        test_reset();
        #2;
        reset_n = 1'b1;
        step();
        n_cmp++; if (bus.out_valid !== 1'b0) begin n_bad++; $display("FAIL ar_after_out_valid got %b want 0", bus.out_valid); end
    endtask

    initial begin
        bus.in_valid = 1'b0; bus.kind = BR_NONE; bus.blu_op = BLU_OP_EQUAL;
        bus.pc = '0; bus.imm = '0; bus.rs1 = '0; bus.rs2 = '0; bus.pred_pc = '0;
        bus.out_ready = 1'b0; bus.redirect_ack = 1'b0; bus.squash = 1'b0;
        #1;
        test_reset();
        step();
        step();
        reset_n = 1'b1;
        test_reset();
        test_cond_mispredict();
        test_cond_not_taken();
        test_jalr_exc();
        test_hold();
        test_squash();
        test_saturate();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/branch_resolve.md
# branch_resolve

Execute-stage branch resolution unit for the CPU core, directly downstream of the BLU. It accepts one control-transfer instruction per handshake and instantiates the BLU to evaluate conditional branches. It computes the actual next PC and compares it with the fetch-predicted PC. On a mismatch it drives a held redirect (plus a flush pulse) toward fetch, while forwarding the link value and any exception to writeback.

## Interface
- `XLEN`, 32: datapath width.
- `clk` in 1: clock.
- `reset_n` in 1: asynchronous, active-low reset.
- `in_valid` in 1: upstream instruction valid.
- `in_ready` out 1: unit can accept this cycle.
- `kind` in `BR_kind`: instruction class, one of `BR_NONE`, `BR_COND`, `BR_JAL`, `BR_JALR`.
- `blu_op` in `BLU_opcode`: condition for `BR_COND`.
- `pc`, `imm`, `rs1`, `rs2` in `XLEN`: instruction PC, sign-extended immediate, and operands.
- `pred_pc` in `XLEN`: next PC the fetch stage speculated.
- `out_valid` out 1 / `out_ready` in 1: writeback handshake.
- `out_link` out `XLEN`: PC+4 for JAL/JALR, 0 otherwise.
- `out_exc` out 1: misaligned-target exception.
- `redirect_valid` out 1 / `redirect_ack` in 1: fetch redirect handshake.
- `redirect_pc` out `XLEN`: corrected next PC.
- `flush` out 1: one-cycle pulse squashing younger instructions.
- `squash` in 1: a trap in a later stage kills the held instruction.
- `mispredict_count` out 32: saturating count of issued redirects.

## Operation
- Accept occurs when `in_valid && in_ready`. On accept, all results are computed combinationally and registered.
- Taken rule:
  - `BR_COND`: taken = BLU `out[0]`.
  - `BR_JAL`, `BR_JALR`: taken = 1.
  - `BR_NONE`: taken = 0.
- Target:
  - `BR_COND` and `BR_JAL`: `pc+imm`.
  - `BR_JALR`: `(rs1+imm) & ~1`.
  - All arithmetic is modulo 2^XLEN; wrap-around is silent.
- Actual next PC = taken ? target : `pc+4`.
- Exception: taken and `target[1:0]!=0`. This sets `out_exc`, suppresses the redirect, and does not count.
- Mispredict: no exception and actual next PC ≠ `pred_pc`. This causes a redirect with `redirect_pc` = actual next PC.
- FSM states:
  - `IDLE`: no instruction held.
  - `BUSY`: writeback result and redirect (if any) both pending.
  - `WAIT_OUT`: redirect done, writeback pending.
  - `WAIT_REDIR`: writeback done, redirect pending.
- Transitions:
  - Accept: `IDLE` → `BUSY`.
  - Writeback handshake (`out_valid && out_ready`) clears the writeback pending item.
  - Redirect handshake (`redirect_valid && redirect_ack`) clears the redirect pending item.
  - Both items cleared: → `IDLE`.
  - Both handshakes in the same cycle from `BUSY`: → `IDLE` directly.
- `in_ready` is high in `IDLE`, or in any state whose remaining pending items all complete this cycle (back-to-back accept).
- Holding rules: `out_*` and `redirect_*` stay stable while their valid is high and unacknowledged.
- `flush` pulses only in the first cycle `redirect_valid` rises for a given instruction.
- `mispredict_count` increments in that same cycle and saturates at `0xFFFFFFFF`.
- `squash` has priority over everything else:
  - Next state is `IDLE`, and all valids drop next cycle.
  - A redirect not yet acknowledged is withdrawn; the count is unchanged.
  - A same-cycle accept is ignored.
- Reset values: `in_ready=1`, `out_valid=0`, `out_link=0`, `out_exc=0`, `redirect_valid=0`, `redirect_pc=0`, `flush=0`, `mispredict_count=0`, state `IDLE`.
- Reset asserted mid-operation returns to the reset values immediately (asynchronously).

## Timing
- Latency is one cycle: accept at edge N gives `out_valid` (and `redirect_valid`/`flush` if mispredicted) high after edge N.
- Peak throughput is one instruction per cycle when `out_ready=1` and no redirect occurs, or the redirect is acknowledged in the same cycle.
- A redirect held for k cycles blocks new accepts for those k cycles.
- The BLU path is combinational in the accept cycle; there is no input register ahead of it.

## Structure
- `blu_pkg` gains:
  - typedef `BR_kind`, a 2-bit enum;
  - typedef `BR_state`, the 4-state FSM enum;
  - constant `BR_PC_STEP = 4`.
- Sub-module: one `BLU` instance fed by `rs1`, `rs2`, `blu_op`.

## Test plan
- `BR_COND`, `BLU_OP_EQUAL`, rs1=rs2=`0xAAAAAAAA`, pc=`0x100`, imm=`0x20`, `pred_pc=0x104` → next cycle `redirect_pc=0x120`, flush pulses once, count=1, `out_link=0`.
- `BR_COND`, `BLU_OP_LESS_THAN_SIGNED`, rs1=`0x7FFFFFFF`, rs2=`0x80000000`, `pred_pc=pc+4` → not taken, no redirect, `out_valid` only, count unchanged.
- `BR_JALR`, rs1=`0x203`, imm=0, pc=`0x40` → target `0x202`, `out_exc=1`, `out_link=0x44`, no redirect.
- `out_ready=0` and `redirect_ack=0` held for 3 cycles after a mispredict → `in_ready=0`, all outputs stable and `flush` high only in the first cycle; ack both together → `IDLE`, and a new accept is possible that cycle.
- `squash` while in `WAIT_REDIR` → `redirect_valid` low next cycle; a later mispredict increments the count by 1 only.
- Preload count `0xFFFFFFFF` via repeated mispredicts or a force → a further mispredict leaves the count at `0xFFFFFFFF`; `reset_n` low mid-`BUSY` → all outputs at reset values without waiting for a clock edge.
